vram_slot_arbiter: RTL and testbench

- Time-slot controller that shares one video RAM between the Z80 CPU and the video scan logic.
- Sequences the external quad 2-to-1 mux-with-storage address bank (74LS298-style, latches on falling clock) by driving its select (`mux_s`) and latch strobe (`mux_clk`).
- Also drives RAM write enable, CPU wait/acknowledge and read-data capture.
- Sits between the CPU bus decode, the video address counters and the VRAM.

---
 rtl/vram_slot_arbiter_pkg.sv | 23 ++
 rtl/vram_slot_arbiter_if.sv | 31 +++
 rtl/vram_slot_arbiter_timer.sv | 56 +++++
 rtl/vram_slot_arbiter.sv | 127 ++++++++++++
 tb/tb_vram_slot_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vram_slot_arbiter_pkg.sv
// Shared types and constants for the VRAM time-slot arbiter.
// Phase encoding, slot ownership, and address-mux select values.
package vram_arb_pkg;

    localparam int SLOT_PHASES = 4;

    localparam logic MUX_SEL_VIDEO = 1'b0;
    localparam logic MUX_SEL_CPU   = 1'b1;

    typedef enum logic [$clog2(SLOT_PHASES)-1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        VIDEO = 2'd0,
        CPU   = 2'd1,
        IDLE  = 2'd2
    } owner_t;

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// VRAM arbiter bus: CPU request side, video sync/enable, RAM and address-mux controls.
// The arbiter takes the slave modport; the surrounding system drives the master side.
interface vram_slot_arbiter_if #(parameter int DATA_W = 8);
    logic              cen;
    logic              vid_sync;
    logic              cpu_req;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] ram_dout;
    logic              mux_s;
    logic              mux_clk;
    logic              ram_we_n;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_wait;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    modport slave (
        input  cen, vid_sync, cpu_req, cpu_we, cpu_wdata, ram_dout,
        output mux_s, mux_clk, ram_we_n, ram_wdata, cpu_wait, cpu_ack,
               cpu_rdata, vid_data, vid_valid
    );

    modport master (
        output cen, vid_sync, cpu_req, cpu_we, cpu_wdata, ram_dout,
        input  mux_s, mux_clk, ram_we_n, ram_wdata, cpu_wait, cpu_ack,
               cpu_rdata, vid_data, vid_valid
    );
endinterface

// File: rtl/vram_slot_arbiter_timer.sv
// Slot timer: 4-phase counter per cen tick, even/odd slot parity, deferred vid_sync realign.
// Latency: phase advances on each cen edge; a pending sync takes effect at the next P3->P0 boundary.
module vram_slot_timer
    import vram_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   cen_i,
    input  logic   vid_sync_i,
    output phase_t phase_o,
    output logic   slot_odd_o
);

    phase_t phase_q, phase_d;
    logic   odd_q, odd_d;
    logic   sync_pend_q, sync_pend_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= P0;
            odd_q       <= 1'b0;
            sync_pend_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            odd_q       <= odd_d;
            sync_pend_q <= sync_pend_d;
        end
    end

    // The strobe is captured on any clk so a short sync pulse between cen ticks is not lost.
    always_comb begin
        phase_d     = phase_q;
        odd_d       = odd_q;
        sync_pend_d = sync_pend_q | vid_sync_i;
        if (cen_i) begin
            case (phase_q)
                P0: phase_d = P1;
                P1: phase_d = P2;
                P2: phase_d = P3;
                P3: begin
                    phase_d = P0;
                    if (sync_pend_d) begin
                        odd_d       = 1'b0;
                        sync_pend_d = 1'b0;
                    end else begin
                        odd_d = ~odd_q;
                    end
                end
            endcase
        end
    end

    assign phase_o    = phase_q;
    assign slot_odd_o = odd_q;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Shares one VRAM between CPU and video scan in alternating 4-phase slots, driving the address mux bank.
// Latency: CPU ack 3 cen ticks after odd-P0 grant; backpressure via registered cpu_wait until ack.
module vram_slot_arbiter
    import vram_arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input logic             clk,
    input logic             reset_n,
    vram_slot_arbiter_if.slave bus
);

    phase_t phase;
    logic   slot_odd;

    vram_slot_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .cen_i      (bus.cen),
        .vid_sync_i (bus.vid_sync),
        .phase_o    (phase),
        .slot_odd_o (slot_odd)
    );

    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic              mux_s_q, mux_s_d;
    logic              mux_clk_q, mux_clk_d;
    logic              we_n_q, we_n_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] vdata_q, vdata_d;
    logic              vvalid_q, vvalid_d;
    logic              ack_q, ack_d;
    logic              wait_q, wait_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q   <= IDLE;
            wr_q      <= 1'b0;
            mux_s_q   <= MUX_SEL_VIDEO;
            mux_clk_q <= 1'b1;
            we_n_q    <= 1'b1;
            wdata_q   <= '0;
            rdata_q   <= '0;
            vdata_q   <= '0;
            vvalid_q  <= 1'b0;
            ack_q     <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            mux_s_q   <= mux_s_d;
            mux_clk_q <= mux_clk_d;
            we_n_q    <= we_n_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            vdata_q   <= vdata_d;
            vvalid_q  <= vvalid_d;
            ack_q     <= ack_d;
            wait_q    <= wait_d;
        end
    end

    // Pulses default low every clk so they last exactly one clk even when cen drops afterwards.
    always_comb begin
        owner_d   = owner_q;
        wr_d      = wr_q;
        mux_s_d   = mux_s_q;
        mux_clk_d = mux_clk_q;
        we_n_d    = we_n_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        vdata_d   = vdata_q;
        vvalid_d  = 1'b0;
        ack_d     = 1'b0;
        wait_d    = wait_q;
        if (bus.cen) begin
            wait_d = bus.cpu_req;
            case (phase)
                P0: begin
                    if (!slot_odd) begin
                        owner_d = VIDEO;
                        mux_s_d = MUX_SEL_VIDEO;
                    end else if (bus.cpu_req) begin
                        owner_d = CPU;
                        mux_s_d = MUX_SEL_CPU;
                        wdata_d = bus.cpu_wdata;
                        wr_d    = bus.cpu_we;
                    end else begin
                        owner_d = IDLE;
                        mux_s_d = MUX_SEL_VIDEO;
                    end
                end
                P1: begin
                    if (owner_q != IDLE) mux_clk_d = 1'b0;
                end
                P2: begin
                    mux_clk_d = 1'b1;
                    if (owner_q == CPU && wr_q) we_n_d = 1'b0;
                end
                P3: begin
                    we_n_d = 1'b1;
                    if (owner_q == VIDEO) begin
                        vdata_d  = bus.ram_dout;
                        vvalid_d = 1'b1;
                    end else if (owner_q == CPU) begin
                        if (!wr_q) rdata_d = bus.ram_dout;
                        ack_d  = 1'b1;
                        wait_d = 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.mux_s     = mux_s_q;
    assign bus.mux_clk   = mux_clk_q;
    assign bus.ram_we_n  = we_n_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.cpu_wait  = wait_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.vid_data  = vdata_q;
    assign bus.vid_valid = vvalid_q;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Directed bench for vram_slot_arbiter: a cycle vector table from reset, then hand sequences.
// Outputs are sampled on the falling clk edge; inputs change right after it.
module tb_vram_slot_arbiter;

    logic clk;
    logic reset_n;

    vram_slot_arbiter_if #(.DATA_W(8)) bus ();

    vram_slot_arbiter #(.DATA_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mux_s, mux_clk, ram_we_n, cpu_wait, cpu_ack, vid_valid}
    logic [5:0] ctl;
    assign ctl = {bus.mux_s, bus.mux_clk, bus.ram_we_n, bus.cpu_wait, bus.cpu_ack, bus.vid_valid};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic req, input logic we, input logic [7:0] wd, input logic [7:0] dout);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_wdata = wd;
        bus.ram_dout  = dout;
    endtask

    typedef struct {
        logic       req;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] dout;
        logic [5:0] exp_ctl;
        logic [7:0] exp_wdata;
        logic [7:0] exp_vdata;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // Edges 1..20 from reset: even, odd idle, even, odd CPU write of 0xA5, even.
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b001000, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h11, 6'b011001, 8'h00, 8'h11};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h11};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h11};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h11};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h55, 6'b011000, 8'h00, 8'h11};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h11};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b001000, 8'h00, 8'h11};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'h00, 8'h11};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h22, 6'b011001, 8'h00, 8'h22};
        vecs[12] = '{1'b1, 1'b1, 8'hA5, 8'h00, 6'b111100, 8'hA5, 8'h22};
        vecs[13] = '{1'b1, 1'b1, 8'hA5, 8'h00, 6'b101100, 8'hA5, 8'h22};
        vecs[14] = '{1'b1, 1'b1, 8'hA5, 8'h00, 6'b110100, 8'hA5, 8'h22};
        vecs[15] = '{1'b1, 1'b1, 8'hA5, 8'h66, 6'b111010, 8'hA5, 8'h22};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h22};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b001000, 8'hA5, 8'h22};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h22};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 8'h33, 6'b011001, 8'hA5, 8'h33};

        reset_n      = 1'b0;
        bus.cen      = 1'b0;
        bus.vid_sync = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step(); step();
        chk("reset_ctl", {26'd0, ctl}, {26'd0, 6'b011000});
        chk("reset_data", {8'd0, bus.ram_wdata, bus.cpu_rdata, bus.vid_data}, 32'd0);

        bus.cen = 1'b1;
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].wdata, vecs[i].dout);
            step();
            chk($sformatf("vec%0d_ctl", i + 1), {26'd0, ctl}, {26'd0, vecs[i].exp_ctl});
            chk($sformatf("vec%0d_data", i + 1), {16'd0, bus.ram_wdata, bus.vid_data},
                {16'd0, vecs[i].exp_wdata, vecs[i].exp_vdata});
        end

        // CPU read raised just after odd P0: serviced a full cycle later, ack 11 ticks after the missed P0.
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("missed_p0_idle", {26'd0, ctl}, {26'd0, 6'b011000});
        for (int n = 1; n <= 11; n++) begin
            drive(1'b1, 1'b0, 8'h00, (n == 11) ? 8'h3C : 8'h77);
            step();
            chk($sformatf("late_read_t%0d", n), {30'd0, bus.cpu_wait, bus.cpu_ack},
                (n < 11) ? 32'd2 : 32'd1);
        end
        chk("late_read_rdata", {24'd0, bus.cpu_rdata}, 32'h3C);
        chk("late_read_vdata", {24'd0, bus.vid_data}, 32'h77);

        // Write granted, request dropped right after grant, vid_sync at odd P1.
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) step();
        drive(1'b1, 1'b1, 8'h5A, 8'h00);
        step();
        chk("sync_wr_grant", {23'd0, ctl, bus.ram_wdata[2:0]}, {23'd0, 6'b111100, 3'b010});
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        bus.vid_sync = 1'b1;
        step();
        bus.vid_sync = 1'b0;
        chk("sync_wr_p1", {26'd0, ctl}, {26'd0, 6'b101000});
        step();
        chk("sync_wr_p2", {26'd0, ctl}, {26'd0, 6'b110000});
        step();
        chk("sync_wr_ack", {26'd0, ctl}, {26'd0, 6'b111010});
        repeat (4) step();
        chk("sync_next_even", {26'd0, ctl}, {26'd0, 6'b011001});
        drive(1'b1, 1'b0, 8'h00, 8'h99);
        step();
        chk("sync_then_odd", {26'd0, ctl}, {26'd0, 6'b111100});
        repeat (3) step();
        chk("rd99_ack", {26'd0, ctl}, {26'd0, 6'b111010});
        chk("rd99_rdata", {24'd0, bus.cpu_rdata}, 32'h99);
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        // vid_sync during an even slot forces a second even slot before the CPU gets its turn.
        step();
        bus.vid_sync = 1'b1;
        step();
        bus.vid_sync = 1'b0;
        step(); step();
        drive(1'b1, 1'b0, 8'h00, 8'h42);
        step();
        chk("forced_even_p0", {26'd0, ctl}, {26'd0, 6'b011100});
        step();
        chk("forced_even_p1", {26'd0, ctl}, {26'd0, 6'b001100});
        step(); step();
        chk("forced_even_p3", {26'd0, ctl}, {26'd0, 6'b011101});
        step();
        chk("after_forced_grant", {26'd0, ctl}, {26'd0, 6'b111100});
        repeat (3) step();
        chk("rd42_ack", {26'd0, ctl}, {26'd0, 6'b111010});
        chk("rd42_rdata", {24'd0, bus.cpu_rdata}, 32'h42);
        drive(1'b0, 1'b0, 8'h00, 8'h00);

        // cen stall in the middle of a write's P2.
        repeat (4) step();
        drive(1'b1, 1'b1, 8'hC3, 8'h00);
        step();
        chk("stall_wdata", {24'd0, bus.ram_wdata}, 32'hC3);
        step(); step();
        chk("stall_p2", {26'd0, ctl}, {26'd0, 6'b110100});
        bus.cen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("stall_hold%0d", n), {26'd0, ctl}, {26'd0, 6'b110100});
        end
        bus.cen = 1'b1;
        step();
        chk("stall_resume_p3", {26'd0, ctl}, {26'd0, 6'b111010});
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        bus.cen = 1'b0;
        step();
        chk("ack_one_clk", {26'd0, ctl}, {26'd0, 6'b111000});
        bus.cen = 1'b1;
        step();
        chk("stall_next_even", {26'd0, ctl}, {26'd0, 6'b011000});

        // Reset asserted during P2 of a write.
        repeat (3) step();
        drive(1'b1, 1'b1, 8'hE7, 8'h00);
        step(); step(); step();
        chk("rst_wr_p2", {26'd0, ctl}, {26'd0, 6'b110100});
        reset_n = 1'b0;
        #1;
        chk("rst_async_ctl", {26'd0, ctl}, {26'd0, 6'b011000});
        chk("rst_async_data", {8'd0, bus.ram_wdata, bus.cpu_rdata, bus.vid_data}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        chk("rst_no_ack", {26'd0, ctl}, {26'd0, 6'b011000});
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 8'h81);
        step();
        chk("restart_even_p0", {26'd0, ctl}, {26'd0, 6'b011100});
        step();
        chk("restart_even_p1", {26'd0, ctl}, {26'd0, 6'b001100});
        step(); step();
        chk("restart_even_p3", {26'd0, ctl}, {26'd0, 6'b011101});
        step();
        chk("restart_odd_grant", {26'd0, ctl}, {26'd0, 6'b111100});
        repeat (3) step();
        chk("restart_ack", {26'd0, ctl}, {26'd0, 6'b111010});
        chk("restart_rdata", {24'd0, bus.cpu_rdata}, 32'h81);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
